// File: rtl/song_sequencer_if.sv
// Control, song ROM and tone-generator signals of the song sequencer.
interface song_sequencer_if #(
  parameter int ADDR_W = 6,
  parameter int NOTE_W = 5,
  parameter int DUR_W  = 3
);
  logic                    start;
  logic                    pause;
  logic                    stop;
  logic [1:0]              tempo_sel;
  logic [ADDR_W-1:0]       rom_addr;
  logic [NOTE_W+DUR_W-1:0] rom_data;
  logic [NOTE_W-1:0]       note;
  logic                    note_on;
  logic                    beat;
  logic                    busy;
  logic                    done;

  modport master (
    output start, pause, stop, tempo_sel, rom_data,
    input  rom_addr, note, note_on, beat, busy, done
  );

  modport slave (
    input  start, pause, stop, tempo_sel, rom_data,
    output rom_addr, note, note_on, beat, busy, done
  );
endinterface

// File: rtl/song_sequencer.sv
// Tempo-driven song ROM player: times each entry in beats and
// gates note_on with an articulation gap before every note boundary.
module song_sequencer #(
  parameter int TICK_CYCLES = 30_000_000,
  parameter int GAP_CYCLES  = 3_000_000,
  parameter int ADDR_W      = 6,
  parameter int NOTE_W      = 5,
  parameter int DUR_W       = 3
) (
  input  logic             clk,
  input  logic             rst,
  song_sequencer_if.slave  io
);
  localparam int CNT_W = $clog2(TICK_CYCLES * 2 + 1);

  localparam logic [CNT_W-1:0] P_NORM = CNT_W'(TICK_CYCLES);
  localparam logic [CNT_W-1:0] P_FAST = CNT_W'(TICK_CYCLES / 2);
  localparam logic [CNT_W-1:0] P_SLOW = CNT_W'(TICK_CYCLES * 2);
  localparam logic [CNT_W-1:0] GAP_C  = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [DUR_W-1:0] REM1   = DUR_W'(1);
  localparam logic [ADDR_W-1:0] AMAX  = '1;
  localparam logic [ADDR_W-1:0] AONE  = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_PLAY,
    S_GAP, S_PAUSED, S_DONE
  } state_t;

  state_t            state_q, state_d;
  state_t            ret_q, ret_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DUR_W-1:0]  rem_q, rem_d;
  logic              on_q, on_d;
  logic              beat_q, beat_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [CNT_W-1:0]  sel_period;
  logic [NOTE_W-1:0] rd_note;
  logic [DUR_W-1:0]  rd_dur;
  logic              tick;

  assign rd_note = io.rom_data[NOTE_W+DUR_W-1:DUR_W];
  assign rd_dur  = io.rom_data[DUR_W-1:0];
  assign tick    = (cnt_q == period_q - ONE);

  always_comb begin
    sel_period = P_NORM;
    unique case (1'b1)
      (io.tempo_sel == 2'b01): sel_period = P_FAST;
      (io.tempo_sel == 2'b10): sel_period = P_SLOW;
      default:                 sel_period = P_NORM;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    addr_d   = addr_q;
    note_d   = note_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    unique case (state_q)
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        if (rd_dur == '0) begin
          state_d = S_DONE;
        end else begin
          state_d  = S_PLAY;
          note_d   = rd_note;
          rem_d    = rd_dur;
          cnt_d    = '0;
          period_d = sel_period;
        end
      end
      S_PLAY, S_GAP: begin
        cnt_d = tick ? '0 : cnt_q + ONE;
        if (tick) rem_d = rem_q - REM1;
        if (state_q == S_PLAY && rem_q == REM1 &&
            cnt_q == period_q - GAP_C - ONE)
          state_d = S_GAP;
        if (state_q == S_GAP && tick) begin
          if (addr_q == AMAX) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
            addr_d  = addr_q + AONE;
          end
        end
        // the pausing cycle still counts; a note boundary wins
        if (io.pause &&
            (state_d == S_PLAY || state_d == S_GAP)) begin
          ret_d   = state_d;
          state_d = S_PAUSED;
        end
      end
      S_PAUSED: if (io.pause) state_d = ret_q;
      default: ;
    endcase
    if (io.start &&
        (state_q == S_IDLE || state_q == S_DONE)) begin
      state_d = S_FETCH;
      addr_d  = '0;
    end
    if (io.stop) begin
      state_d = S_IDLE;
      addr_d  = '0;
      note_d  = '0;
      cnt_d   = '0;
      rem_d   = '0;
    end
  end

  always_comb begin
    on_d   = (state_d == S_PLAY) && (note_d != '0);
    beat_d = (state_d == S_PLAY || state_d == S_GAP) &&
             (cnt_d == period_d - ONE);
    busy_d = !(state_d == S_IDLE || state_d == S_DONE);
    done_d = (state_d == S_DONE) && (state_q != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ret_q    <= S_PLAY;
      addr_q   <= '0;
      note_q   <= '0;
      period_q <= '0;
      cnt_q    <= '0;
      rem_q    <= '0;
      on_q     <= 1'b0;
      beat_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ret_q    <= ret_d;
      addr_q   <= addr_d;
      note_q   <= note_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      on_q     <= on_d;
      beat_q   <= beat_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign io.rom_addr = addr_q;
  assign io.note     = note_q;
  assign io.note_on  = on_q;
  assign io.beat     = beat_q;
  assign io.busy     = busy_q;
  assign io.done     = done_q;
endmodule
